// File: rtl/mac_accumulator.sv
// Streaming dot-product engine: per beat, multiply LANES operand pairs, reduce them in
// an adder tree, and accumulate across beats until in_last; results wait in a held register.
module mac_accumulator #(
  parameter int LANES  = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   x_in,
  input  logic [LANES*DW-1:0]   w_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [15:0]           out_beats
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(LANES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  // Handshake: a beat moves on in_valid & in_ready. The only back-pressure
  // source is an unaccepted result, and it freezes the whole pipeline.
  logic stall;
  logic take;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign take     = in_valid & in_ready & ~clear;

  logic [PW-1:0] prod [LANES];

  // Operands are widened by one bit (sign or zero) so one signed multiplier
  // serves both operand modes.
  for (genvar g = 0; g < LANES; g++) begin : g_mul
    logic signed [DW:0]     xa;
    logic signed [DW:0]     wa;
    logic signed [2*DW+1:0] full;
    assign xa      = {(SIGNED != 0) && x_in[g*DW+DW-1], x_in[g*DW +: DW]};
    assign wa      = {(SIGNED != 0) && w_in[g*DW+DW-1], w_in[g*DW +: DW]};
    assign full    = xa * wa;
    assign prod[g] = full[PW-1:0];
  end

  logic          s1_valid;
  logic          s1_last;
  logic [PW-1:0] s1_p [LANES];

  logic          s2_valid;
  logic          s2_last;
  logic [SW-1:0] s2_sum;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [15:0]      cnt;

  logic [SW-1:0]    sum;
  logic [ACC_W-1:0] s_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [15:0]      cnt_inc;

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + {{(SW-PW){(SIGNED != 0) && s1_p[i][PW-1]}}, s1_p[i]};
    end
  end

  assign s_ext   = (SIGNED != 0) ? ACC_W'($signed(s2_sum)) : ACC_W'(s2_sum);
  assign acc_sum = acc + s_ext;
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_p[i] <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= take;
      if (take) begin
        s1_last <= in_last;
        for (int i = 0; i < LANES; i++) s1_p[i] <= prod[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_sum  <= sum;
      end
    end
  end

  // Accumulate FSM. When not stalled, any pending result has been accepted
  // this cycle, so out_valid simply follows whether a new result is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          out_data  <= (state == ACCUM) ? acc_sum : s_ext;
          out_beats <= (state == ACCUM) ? cnt_inc : 16'd1;
          acc       <= '0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          acc   <= (state == ACCUM) ? acc_sum : s_ext;
          cnt   <= (state == ACCUM) ? cnt_inc : 16'd1;
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a signed instance plus an unsigned twin on
// the same stimulus, each scenario checking its own hand-computed results.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_beats;

  logic        u_in_ready;
  logic        u_out_valid;
  logic [31:0] u_out_data;
  logic [15:0] u_out_beats;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.LANES(4), .DW(8), .ACC_W(32), .SIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .x_in(x_in), .w_in(w_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
  );

  mac_accumulator #(.LANES(4), .DW(8), .ACC_W(32), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_last(in_last), .x_in(x_in), .w_in(w_in), .out_valid(u_out_valid),
    .out_ready(out_ready), .out_data(u_out_data), .out_beats(u_out_beats)
  );

  function automatic logic [31:0] pack4(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Driver: called at a negedge, holds the beat until an edge where in_ready
  // was high, returns at the following negedge with in_valid dropped.
  task automatic send(input logic [31:0] x, input logic [31:0] w, input logic last);
    int k = 0;
    x_in = x; w_in = w; in_last = last; in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_timeout: in_ready got %0b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    x_in = '0; w_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %0d expected 0", out_data); end
    n_cmp++; if (out_beats !== 16'd0) begin n_err++; $display("FAIL rst_beats: got %0d expected 0", out_beats); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    n_cmp++; if (u_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_u_in_ready: got %0b expected 1", u_in_ready); end
  endtask

  task automatic test_unsigned_latency();
    send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t1: got %0b expected 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t2: got %0b expected 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_t3: got %0b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'd70) begin n_err++; $display("FAIL one_beat_data: got %0d expected 70", out_data); end
    n_cmp++; if (out_beats !== 16'd1) begin n_err++; $display("FAIL one_beat_beats: got %0d expected 1", out_beats); end
    n_cmp++; if (u_out_data !== 32'd70) begin n_err++; $display("FAIL one_beat_u_data: got %0d expected 70", u_out_data); end
    @(negedge clk);
  endtask

  task automatic test_signed();
    bit ok;
    send(pack4(8'hFF, 8'h80, 8'h7F, 8'h00), pack4(8'h01, 8'h80, 8'h7F, 8'h09), 1'b1);
    wait_out(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL signed_timeout: out_valid got 0 expected 1"); end
    n_cmp++; if (out_data !== 32'd32512) begin n_err++; $display("FAIL signed_data: got %0d expected 32512", out_data); end
    n_cmp++; if (u_out_valid !== 1'b1 || u_out_data !== 32'd32768) begin
      n_err++; $display("FAIL unsigned_twin_data: got %0d expected 32768", u_out_data);
    end
    @(negedge clk);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_out(ok);
    n_cmp++; if (out_data !== 32'd4) begin n_err++; $display("FAIL signed_all_ones: got %0d expected 4", out_data); end
    n_cmp++; if (u_out_data !== 32'd260100) begin n_err++; $display("FAIL unsigned_all_ones: got %0d expected 260100", u_out_data); end
    @(negedge clk);
  endtask

  task automatic test_multi_bubble();
    bit ok;
    send(32'h0101_0101, 32'h0101_0101, 1'b0);
    send(32'h0101_0101, 32'h0101_0101, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_early: got %0b expected 0", out_valid); end
    send(32'h0101_0101, 32'h0101_0101, 1'b1);
    wait_out(ok);
    n_cmp++; if (!ok || out_data !== 32'd12) begin n_err++; $display("FAIL bubble_data: got %0d expected 12", out_data); end
    n_cmp++; if (out_beats !== 16'd3) begin n_err++; $display("FAIL bubble_beats: got %0d expected 3", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    send(32'h0101_0101, 32'h0202_0202, 1'b1);
    send(pack4(1, 2, 3, 4), 32'h0101_0101, 1'b0);
    send(pack4(1, 2, 3, 4), 32'h0101_0101, 1'b1);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd8) begin n_err++; $display("FAIL bp_first: got %0d expected 8", out_data); end
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd8) begin n_err++; $display("FAIL bp_hold: got %0d expected 8", out_data); end
    n_cmp++; if (out_beats !== 16'd1) begin n_err++; $display("FAIL bp_first_beats: got %0d expected 1", out_beats); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_gap: got %0b expected 0", out_valid); end
    wait_out(ok);
    n_cmp++; if (!ok || out_data !== 32'd20) begin n_err++; $display("FAIL bp_second: got %0d expected 20", out_data); end
    n_cmp++; if (out_beats !== 16'd2) begin n_err++; $display("FAIL bp_second_beats: got %0d expected 2", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send(pack4(1, 0, 0, 0), pack4(5, 0, 0, 0), 1'b1);
    send(pack4(0, 0, 0, 1), pack4(0, 0, 0, 7), 1'b1);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd5) begin n_err++; $display("FAIL b2b_first: got %0d expected 5", out_data); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin n_err++; $display("FAIL b2b_second: got %0d expected 7", out_data); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_clear();
    bit ok;
    send(32'h0101_0101, 32'h0101_0101, 1'b0);
    send(32'h0101_0101, 32'h0101_0101, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    x_in = 32'h0101_0101; w_in = 32'h0101_0101;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %0b expected 0", out_valid); end
    send(32'h0202_0202, 32'h0303_0303, 1'b1);
    wait_out(ok);
    n_cmp++; if (!ok || out_data !== 32'd24) begin n_err++; $display("FAIL clear_data: got %0d expected 24", out_data); end
    n_cmp++; if (out_beats !== 16'd1) begin n_err++; $display("FAIL clear_beats: got %0d expected 1", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    send(32'h0101_0101, 32'h0101_0101, 1'b1);
    send(32'h0101_0101, 32'h0101_0101, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd4) begin n_err++; $display("FAIL rmid_pre: got %0d expected 4", out_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0 || out_beats !== 16'd0) begin
      n_err++; $display("FAIL rmid_zero: got data %0d beats %0d expected 0 0", out_data, out_beats);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    send(pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), 1'b1);
    wait_out(ok);
    n_cmp++; if (!ok || out_data !== 32'd20) begin n_err++; $display("FAIL rmid_after: got %0d expected 20", out_data); end
    n_cmp++; if (out_beats !== 16'd1) begin n_err++; $display("FAIL rmid_beats: got %0d expected 1", out_beats); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_latency();
    test_signed();
    test_multi_bubble();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
